// File: rtl/dontcare_arb_pkg.sv
// Shared constants and the round-robin search function for the don't-care arbiter.
// DONTCARE_ZERO_EN turns every don't-care fill into all-zero instead of 'x.
package dontcare_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int MAX_REQ     = 16;
    localparam int MAX_SRC_W   = 4;
    localparam int MAX_DC_W    = 1024;

`ifdef DONTCARE_ZERO_EN
    localparam logic DC_BIT = 1'b0;
`else
    localparam logic DC_BIT = 1'bx;
`endif

    // Wide fills so users can slice the width they need without zero-extending an 'x.
    localparam logic [MAX_DC_W-1:0]  DC_DATA = {MAX_DC_W{DC_BIT}};
    localparam logic [MAX_SRC_W-1:0] DC_SRC  = {MAX_SRC_W{DC_BIT}};

    // Returns {found, index}; scan starts one past last and wraps modulo n.
    function automatic logic [MAX_SRC_W:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input int unsigned last,
                                                   input int unsigned n);
        logic        found;
        int unsigned idx;
        int unsigned pos;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            pos = last + k;
            if (pos >= n)
                pos = pos - n;
            if (k <= n && !found && valid[pos[MAX_SRC_W-1:0]]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
        return {found, idx[MAX_SRC_W-1:0]};
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin finder: first valid requester after last, wrapping.
module rr_priority_pick
    import dontcare_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [SRC_W-1:0]   last,
    output logic               found,
    output logic [SRC_W-1:0]   winner
);

    logic [MAX_SRC_W:0] pick;

    always_comb begin
        pick   = rr_pick(MAX_REQ'(valid), 32'(last), NUM_REQ);
        found  = pick[MAX_SRC_W];
        winner = SRC_W'(pick[MAX_SRC_W-1:0]);
    end

endmodule

// File: rtl/dontcare_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry registered output slot.
// Build with DONTCARE_ZERO_EN to drive zeros instead of 'x into idle data/source fields.
module dontcare_rr_arbiter
    import dontcare_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int DATA_W  = DEF_DATA_W,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        in_valid,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    output logic [NUM_REQ-1:0]        in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready
);

    localparam logic [DATA_W-1:0] DC_D       = DC_DATA[DATA_W-1:0];
    localparam logic [SRC_W-1:0]  DC_S       = DC_SRC[SRC_W-1:0];
    localparam logic [SRC_W-1:0]  LAST_RESET = SRC_W'(NUM_REQ - 1);

    logic [SRC_W-1:0] last_grant;
    logic             found;
    logic [SRC_W-1:0] winner;
    logic             can_load;
    logic             accept;

    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid  (in_valid),
        .last   (last_grant),
        .found  (found),
        .winner (winner)
    );

    // The slot is EMPTY/FULL purely by out_valid; a draining slot can reload in the same cycle.
    always_comb begin
        can_load = !out_valid || out_ready;
        accept   = can_load && found;
        in_ready = accept ? (NUM_REQ'(1) << winner) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= DC_D;
            out_src    <= DC_S;
            last_grant <= LAST_RESET;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= in_data[winner*DATA_W +: DATA_W];
            out_src    <= winner;
            last_grant <= winner;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
            out_data   <= DC_D;
            out_src    <= DC_S;
        end
    end

endmodule

// File: tb/tb_dontcare_rr_arbiter.sv
// Self-checking bench for dontcare_rr_arbiter: directed scenarios plus a randomized run
// against a behavioural slot/arbitration model.
module tb_dontcare_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic            clock;
    logic            reset_n;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic            out_ready;

    int n_checks;
    int n_fail;

    // Behavioural model state
    bit       m_valid;
    bit [7:0] m_data;
    int       m_src;
    int       m_last;

    dontcare_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int m_winner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int  w;
        bit  cl;
        w  = m_winner(in_valid, m_last);
        cl = !m_valid || out_ready;
        if (cl && w >= 0) return N'(1) << w;
        return '0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_last  = N - 1;
    endtask

    task automatic model_clock();
        int w;
        bit cl;
        w  = m_winner(in_valid, m_last);
        cl = !m_valid || out_ready;
        if (cl && w >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[w*DW +: DW];
            m_src   = w;
            m_last  = w;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        in_data = 32'h44332211;
        do_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
`ifdef DONTCARE_ZERO_EN
        n_checks++;
        if (out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out_data_zero: got %h want 00", out_data);
        end
`endif
    endtask

    task automatic test_single_beat();
        in_data   = {8'h11, 8'hA5, 8'h22, 8'h33};
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_in_ready: got %b want 0100", in_ready);
        end
        tick();
        in_valid = 4'b0000;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2) begin
            n_fail++;
            $display("FAIL single_beat: got v=%b d=%h s=%0d want v=1 d=a5 s=2",
                     out_valid, out_data, out_src);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        in_data   = 32'h44332211;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || int'(out_src) != (k % N)) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got v=%b src=%0d want v=1 src=%0d",
                         k, out_valid, out_src, k % N);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_data   = 32'h44332211;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 8'h22) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got rdy=%b v=%b s=%0d d=%h want rdy=0000 v=1 s=1 d=22",
                         k, in_ready, out_valid, out_src, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 8'h33) begin
            n_fail++;
            $display("FAIL backpressure_release: got v=%b s=%0d d=%h want v=1 s=2 d=33",
                     out_valid, out_src, out_data);
        end
    endtask

    task automatic test_wrap();
        int exp_src [3] = '{1, 3, 1};
        do_reset();
        in_data   = 32'hD4C3B2A1;
        in_valid  = 4'b1000;
        out_ready = 1'b1;
        tick();
        in_valid = 4'b1010;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL wrap_in_ready: got %b want 0010", in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || int'(out_src) != exp_src[k]) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got v=%b src=%0d want v=1 src=%0d",
                         k, out_valid, out_src, exp_src[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_drop: got out_valid=%b want 0", out_valid);
        end
        in_valid = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n   = 1'b1;
        in_valid  = 4'b0110;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL async_reset_first_ready: got %b want 0010", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd1) begin
            n_fail++;
            $display("FAIL async_reset_first_grant: got v=%b src=%0d want v=1 src=1",
                     out_valid, out_src);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_rdy;
        do_reset();
        in_valid  = '0;
        in_data   = $urandom;
        out_ready = 1'b0;
        for (int c = 0; c < 400; c++) begin
            #1;
            exp_rdy = m_ready();
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL random_in_ready[%0d]: got %b want %b", c, in_ready, exp_rdy);
            end
            tick();
            n_checks++;
            if (out_valid !== m_valid) begin
                n_fail++;
                $display("FAIL random_out_valid[%0d]: got %b want %b", c, out_valid, m_valid);
            end else if (m_valid) begin
                n_checks++;
                if (out_data !== m_data || int'(out_src) != m_src) begin
                    n_fail++;
                    $display("FAIL random_beat[%0d]: got d=%h s=%0d want d=%h s=%0d",
                             c, out_data, out_src, m_data, m_src);
                end
            end
            // Requesters hold valid/data until granted; idle or just-granted ones may change.
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || exp_rdy[i]) begin
                    in_valid[i]            = ($urandom_range(0, 99) < 55);
                    in_data[i*DW +: DW]    = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        m_data = '0;
        m_src  = 0;
        test_reset();
        test_single_beat();
        test_rotation();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dontcare_rr_arbiter.md
Name: dontcare_rr_arbiter

Overview:
- Round-robin arbiter and mux that shares one registered output slot among NUM_REQ valid/ready requesters.
- Sits in front of any single-port consumer.
- The output data and source fields are don't-care whenever out_valid is low. This exercises the codebase's DONTCARE-to-'x' translation on sequential state, not only on function returns.
- One-entry output register, one-cycle latency, full throughput under continuous out_ready.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, payload width per requester
SRC_W, $clog2(NUM_REQ), width of winning-source index (derived, not overridden)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  NUM_REQ  per-requester valid
in_data  input  NUM_REQ*DATA_W  packed payloads; requester i owns bits [i*DATA_W +: DATA_W]
in_ready  output  NUM_REQ  per-requester ready (combinational)
out_valid  output  1  output slot holds a beat
out_data  output  DATA_W  payload of held beat; don't-care when out_valid=0
out_src  output  SRC_W  index of requester that supplied held beat; don't-care when out_valid=0
out_ready  input  1  consumer accepts beat

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0
  - out_data=DATA_W'(1'bx), out_src=SRC_W'(1'bx)
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset
- State: EMPTY (out_valid=0) and FULL (out_valid=1). State is encoded by out_valid; no separate register.
- can_load = !out_valid || out_ready.
- Arbitration (combinational):
  - Scan i = last_grant+1 … last_grant+NUM_REQ, mod NUM_REQ.
  - The first i with in_valid[i]=1 is the winner.
  - No winner if in_valid==0.
- in_ready[i] = can_load && (i == winner). At most one bit is set; in_ready=0 when there is no winner.
- Accept = can_load && winner exists. On the clock edge after Accept:
  - out_data <= in_data[winner]
  - out_src <= winner
  - out_valid <= 1
  - last_grant <= winner
- If out_valid && out_ready && !Accept: out_valid <= 0, out_data/out_src <= don't-care, last_grant unchanged.
- FULL && !out_ready: hold all registers; in_ready=0.
- Back-to-back: when FULL, out_ready=1 and a requester is valid, drain and reload happen in the same cycle. out_valid stays 1.
- Latency: 1 cycle from in_valid&&in_ready to out_valid.
- Fairness: with all requesters continuously valid and out_ready=1, grants rotate 0,1,…,NUM_REQ-1,0,…
- Wrap-around: last_grant=NUM_REQ-1 wraps the scan to index 0. Arithmetic is modulo NUM_REQ and does not assume NUM_REQ is a power of two.
- Requester protocol: a requester must hold in_valid and in_data stable until it sees in_ready. The arbiter does not check this.
- Reset mid-operation: the held beat is discarded and out_valid drops immediately (async). Nothing is replayed.

Optional Feature:
- Macro: DONTCARE_ZERO_EN.
- Defined: every don't-care assignment (reset values, drain values of out_data/out_src) drives all-zero instead of 'x. Use for lint/equivalence flows and X-pessimistic gate sim.
- Undefined: those assignments drive 'x (DATA_W'(1'bx), SRC_W'(1'bx)).
- Scope: affects only fields qualified by out_valid=0. Handshake and arbitration are identical in both builds.

Decomposition:
- Package dontcare_arb_pkg holds:
  - DC_DATA / DC_SRC constants (width-cast don't-care or zero, selected by DONTCARE_ZERO_EN)
  - default NUM_REQ and DATA_W
  - function rr_pick(valid, last) returning {found, index}
- One sub-module is natural: rr_priority_pick (combinational round-robin finder, NUM_REQ parameter).
- Slot register and handshake stay in the top module.

Test Plan:
- Reset: hold reset_n=0 3 cycles, release -> out_valid=0, in_ready=0. out_data is 8'hxx (or 8'h00 with DONTCARE_ZERO_EN).
- Single beat: in_valid=4'b0100, data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=8'hA5, out_src=2. Following cycle out_valid=0.
- Rotation: in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3, out_valid continuously 1.
- Backpressure: FULL with out_src=1, out_ready=0 for 5 cycles, in_valid=4'b1111 -> in_ready=0, out_data/out_src stable. Then out_ready=1 -> next out_src=2.
- Wrap with sparse requests: last_grant=3, in_valid=4'b1010 -> winner 1; next beat winner 3; next beat winner 1.
- Async reset mid-stream: assert reset_n=0 between edges while out_valid=1 -> out_valid=0 immediately. After release, the first grant goes to the lowest valid index.
